// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
//
// Oversampling UART receive front end: synchronises the raw rx pin, validates
// start bits, recovers each frame (LSB first, no parity, one stop bit) by a
// 3-sample majority vote around mid-bit, and flags framing errors and breaks.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rx            raw serial input, asynchronous to clk, idle high
//   enable        gates detection of a new start bit only
//   data          last correctly framed payload, held until the next one
//   data_valid    one-cycle pulse, data was just updated
//   frame_error   one-cycle pulse, stop bit voted low with non-zero payload
//   break_detect  one-cycle pulse, whole frame (payload and stop) low
//   busy          high whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, counters held at 0, waiting for rx_s low
// START     | validating the start bit; a high vote is a glitch
// DATA      | collecting PAYLOAD_BITS votes into the shift register
// STOP      | stop-bit vote decides data_valid / frame_error / break
// WAIT_HIGH | after an error, waiting for the line to return high

module uart_rx_oversampler #(
    parameter int CLOCK_FREQ   = 25000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    input  logic                    enable,
    output logic [PAYLOAD_BITS-1:0] data,
    output logic                    data_valid,
    output logic                    frame_error,
    output logic                    break_detect,
    output logic                    busy
);

    localparam int DIV_RAW = CLOCK_FREQ / (BIT_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(PAYLOAD_BITS + 2);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_A       = SW'(M - 1);
    localparam logic [SW-1:0] S_B       = SW'(M);
    localparam logic [SW-1:0] S_VOTE    = SW'(M + 1);
    localparam logic [BW-1:0] B_LAST    = BW'(PAYLOAD_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state_q, state_d;

    logic                    rx_meta, rx_s;
    logic [CW-1:0]           tick_cnt;
    logic                    tick;
    logic [SW-1:0]           sidx;
    logic [BW-1:0]           bidx;
    logic                    samp_a, samp_b;
    logic                    vote;
    logic                    vote_now;
    logic                    wrap;
    logic [PAYLOAD_BITS-1:0] shreg, shreg_next;
    logic                    dv_d, fe_d, bd_d;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick     = (state_q != IDLE) && (tick_cnt == TICK_LAST);
    assign vote_now = tick && (sidx == S_VOTE);
    assign wrap     = tick && (sidx == S_LAST);

    // The third vote sample is the live rx_s on the vote tick itself.
    assign vote = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            sidx     <= '0;
            bidx     <= '0;
        end else if (state_q == IDLE) begin
            tick_cnt <= '0;
            sidx     <= '0;
            bidx     <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            if (sidx == S_LAST) begin
                sidx <= '0;
                bidx <= bidx + 1'b1;
            end else begin
                sidx <= sidx + 1'b1;
            end
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick) begin
            if (sidx == S_A) samp_a <= rx_s;
            if (sidx == S_B) samp_b <= rx_s;
        end
    end

    // LSB first: each vote enters at the top and moves down, so after
    // PAYLOAD_BITS votes the first received bit sits in bit 0.
    always_comb begin
        shreg_next                   = shreg >> 1;
        shreg_next[PAYLOAD_BITS-1]   = vote;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if ((state_q == DATA) && vote_now) begin
            shreg <= shreg_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        bd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !rx_s) state_d = START;
            end
            START: begin
                // A vote of 1 was a glitch; otherwise the wrap ends the start bit.
                if (vote_now && vote) state_d = IDLE;
                else if (wrap)        state_d = DATA;
            end
            DATA: begin
                if (wrap && (bidx == B_LAST)) state_d = STOP;
            end
            STOP: begin
                if (vote_now) begin
                    if (vote) begin
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else if (shreg == '0) begin
                        bd_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data         <= '0;
            data_valid   <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
        end else begin
            data_valid   <= dv_d;
            frame_error  <= fe_d;
            break_detect <= bd_d;
            if (dv_d) data <= shreg;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
